// File: rtl/ec_point_check.sv
// ec_point_check: tests y^2 == x^3 + a*x + b (mod p) with one shared serial modular multiplier.
// Optional macro EC_POINT_CHECK_INFINITY_EN: a latched (0,0) is the point at infinity and passes at once.
module ec_point_check #(
    parameter int n = 193
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] p,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         on_curve
);
    localparam int cw = $clog2(n);
    localparam logic [cw-1:0] cmax = cw'(n - 1);

    typedef enum logic [3:0] {IDLE, MUL_YY, MUL_XX, MUL_XXX, MUL_AX, ADD1, ADD2, CMP, DONE} state_t;

    state_t        st, nxt;
    logic [n-1:0]  rp, ra, rb, rx, ry, t_yy, t_xx, t_xxx, t_ax, s, mop, add_a, add_b, add_r;
    logic [n+1:0]  acc, m0, m1, m2, p2;
    logic [n:0]    sum;
    logic [cw-1:0] cnt;
    logic          mbit, last, is_mul, inf;

`ifdef EC_POINT_CHECK_INFINITY_EN
    assign inf = rx == '0 && ry == '0;
`else
    assign inf = 1'b0;
`endif

    // y*y scans y; every other product scans x, so only the added operand changes
    assign mop    = st == MUL_YY ? ry : st == MUL_XX ? rx : st == MUL_XXX ? t_xx : ra;
    assign mbit   = st == MUL_YY ? ry[cnt] : rx[cnt];
    assign is_mul = st inside {MUL_YY, MUL_XX, MUL_XXX, MUL_AX};
    assign last   = cnt == '0;
    assign p2     = {2'b00, rp};
    assign m0     = (acc << 1) + (mbit ? {2'b00, mop} : '0);
    assign m1     = m0 >= p2 ? m0 - p2 : m0;
    assign m2     = m1 >= p2 ? m1 - p2 : m1;

    assign add_a = st == ADD1 ? t_xxx : s;
    assign add_b = st == ADD1 ? t_ax : rb;
    assign sum   = {1'b0, add_a} + {1'b0, add_b};
    assign add_r = sum[n-1:0] - (sum >= {1'b0, rp} ? rp : '0);

    always_ff @(posedge clk) begin
        st <= !reset ? IDLE : nxt;
    end

    always_comb begin
        nxt  = st;
        busy = st != IDLE && st != DONE;
        done = st == DONE;
        case (st)
            IDLE:    nxt = start ? MUL_YY : IDLE;
            MUL_YY:  nxt = inf ? DONE : last ? MUL_XX : MUL_YY;
            MUL_XX:  nxt = last ? MUL_XXX : MUL_XX;
            MUL_XXX: nxt = last ? MUL_AX : MUL_XXX;
            MUL_AX:  nxt = last ? ADD1 : MUL_AX;
            ADD1:    nxt = ADD2;
            ADD2:    nxt = CMP;
            CMP:     nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            {rp, ra, rb, rx, ry} <= '0;
            {t_yy, t_xx, t_xxx, t_ax, s} <= '0;
            acc      <= '0;
            cnt      <= '0;
            on_curve <= 1'b0;
        end else begin
            if (st == IDLE && start) begin
                {rp, ra, rb, rx, ry} <= {p, a, b, x, y};
                acc      <= '0;
                cnt      <= cmax;
                on_curve <= 1'b0;
            end
            if (is_mul) begin
                acc <= last ? '0 : m2;
                cnt <= last ? cmax : cnt - cw'(1);
            end
            if (last && st == MUL_YY) t_yy <= m2[n-1:0];
            if (last && st == MUL_XX) t_xx <= m2[n-1:0];
            if (last && st == MUL_XXX) t_xxx <= m2[n-1:0];
            if (last && st == MUL_AX) t_ax <= m2[n-1:0];
            if (st == ADD1 || st == ADD2) s <= add_r;
            if (st == CMP) on_curve <= t_yy == s;
            if (st == MUL_YY && inf) on_curve <= 1'b1;
        end
    end
endmodule

// File: doc/ec_point_check.md
EC_POINT_CHECK -- requirements
Module: ec_point_check

Interface
REQ-001 SHALL have parameter n, default 193: width of all field operands and of p.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port start, input, 1: request to check one point; sampled only in IDLE.
REQ-005 SHALL have port p, input, n: field prime; value below 2^(n-1) and odd.
REQ-006 SHALL have ports a and b, input, n each: curve coefficients of y^2 = x^3 + a*x + b mod p; each below p.
REQ-007 SHALL have ports x and y, input, n each: affine point under test, typically a result x3/y3 pair from double_and_add; each below p.
REQ-008 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking that on_curve is valid.
REQ-010 SHALL have port on_curve, output, 1: verdict; held stable from done until the next accepted start.

Function
REQ-011 SHALL have states IDLE, MUL_YY, MUL_XX, MUL_XXX, MUL_AX, ADD1, ADD2, CMP and DONE.
REQ-012 SHALL, in IDLE with start=1, latch p, a, b, x, y into internal registers and go to MUL_YY; later input changes SHALL have no effect.
REQ-013 SHALL run every MUL state for exactly n cycles as an MSB-first interleaved modular multiply (acc = 2*acc + bit*operand, then up to two conditional subtractions of p) using an accumulator n+2 bits wide; the result SHALL be fully reduced below p.
REQ-014 SHALL use the MUL states to compute, in order: y*y into t_yy, x*x into t_xx, t_xx*x into t_xxx, and a*x into t_ax.
REQ-015 SHALL compute s = (t_xxx + t_ax) mod p in ADD1 and s = (s + b) mod p in ADD2; each is one cycle using n+1-bit add and one conditional subtraction.
REQ-016 SHALL set on_curve = (t_yy == s) in CMP and go to DONE.
REQ-017 SHALL assert done in DONE for exactly one cycle, with busy low, then return to IDLE.
REQ-018 SHALL assert done 4n+4 rising edges after the edge that samples start; for n=193 this is 776 edges.
REQ-019 SHALL ignore start whenever the state is not IDLE, including the DONE cycle; a start pending on the DONE cycle is not accepted.
REQ-020 SHALL accept a start held high in IDLE immediately on return to IDLE (back-to-back checks).

Reset
REQ-021 SHALL, on any edge with reset=0, force state to IDLE and clear done, busy, on_curve, all accumulators and all temporaries to 0.
REQ-022 SHALL let reset mid-operation abort the check with no done pulse; reset takes priority over start.

Configuration
REQ-023 SHALL recognise the macro EC_POINT_CHECK_INFINITY_EN.
REQ-024 SHALL, with EC_POINT_CHECK_INFINITY_EN defined, treat x=0 and y=0 latched in IDLE as the point at infinity.
REQ-025 SHALL, for a point at infinity under REQ-024, go directly to DONE with on_curve=1, so that done asserts 2 edges after start is sampled.
REQ-026 SHALL, without EC_POINT_CHECK_INFINITY_EN, evaluate (0,0) through the normal path, giving on_curve=1 only if b mod p == 0.

Verification
REQ-027 SHALL test: n=8, p=17, a=2, b=2, (x,y)=(5,1), start -> done at edge 36, on_curve=1.
REQ-028 SHALL test: same curve, (x,y)=(5,2) -> done at edge 36, on_curve=0.
REQ-029 SHALL test: n=193 with the P-192 curve:
- p = fffffffffffffffffffffffffffffffeffffffffffffffff
- a = p-3
- b = 64210519e59c80e70fa7e9ab72243049feb8deecc146b9b1
- G = (188da80eb03090f67cbf20eb43a18800f4ff0afd82ff1012, 07192b95ffc8da78631011ed6b24cdd573f977a11e794811)
-> done at edge 776, on_curve=1; with y flipped in bit 0 -> on_curve=0.
REQ-030 SHALL test: reset driven low at edge 100 of a check -> no done, busy=0 and on_curve=0 next cycle; a new start then completes normally.
REQ-031 SHALL test: start pulsed again during MUL_XX, and start held high through DONE -> the first check is unaffected; exactly one extra check starts after DONE.
REQ-032 SHALL test: (0,0) on p=17, b=2 -> with EC_POINT_CHECK_INFINITY_EN, done at edge 2 with on_curve=1; without it, done at edge 36 with on_curve=0.
